// File: rtl/pcie_tlp_rx_router.sv
// rtl/pcie_tlp_rx_router.sv - TLP RX router: steers requests/completions, drops the rest, keeps stats
`timescale 1ns/1ps

module pcie_tlp_rx_router_skid #(
  parameter int W = 262
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_beat,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_beat,
  input  logic         i_ready
);
  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_cnt;
  logic         r_full;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign w_pop     = (r_cnt != 2'd0) & i_ready;
  assign w_push    = i_push & ~r_full;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_e0   <= '0;
      r_e1   <= '0;
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else begin
      // r_e0 is always the head; push while full cannot happen since ready is low
      if (w_pop) begin
        if (r_cnt == 2'd2) r_e0 <= r_e1;
        else if (w_push)   r_e0 <= i_beat;
      end else if (w_push) begin
        if (r_cnt == 2'd0) r_e0 <= i_beat;
        else               r_e1 <= i_beat;
      end
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == 2'd2);
    end
  end

  assign o_ready = ~r_full;
  assign o_valid = (r_cnt != 2'd0);
  assign o_beat  = r_e0;
endmodule

module pcie_tlp_rx_router #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [255:0]     in_data,
  input  logic [2:0]       in_empty,
  input  logic             in_startofpacket,
  input  logic             in_endofpacket,
  input  logic             in_error,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [255:0]     req_data,
  output logic [2:0]       req_empty,
  output logic             req_startofpacket,
  output logic             req_endofpacket,
  output logic             req_error,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [255:0]     cpl_data,
  output logic [2:0]       cpl_empty,
  output logic             cpl_startofpacket,
  output logic             cpl_endofpacket,
  output logic             cpl_error,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [CNT_W-1:0] req_pkt_count,
  output logic [CNT_W-1:0] cpl_pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] framing_err_count
);
  typedef enum logic [1:0] {S_IDLE, S_FWD_REQ, S_FWD_CPL, S_DROP} state_t;
  typedef enum logic [1:0] {C_REQ, C_CPL, C_DROP} cls_t;

  state_t           r_state;
  state_t           w_state_nxt;
  cls_t             w_cls;
  logic             w_rdy;
  logic             w_acc;
  logic             w_req_push;
  logic             w_cpl_push;
  logic             w_force_close;
  logic             w_inc_req;
  logic             w_inc_cpl;
  logic             w_inc_drop;
  logic             w_inc_frm;
  logic             w_req_buf_rdy;
  logic             w_cpl_buf_rdy;
  logic [261:0]     w_fwd_beat;
  logic [261:0]     w_req_beat;
  logic [261:0]     w_cpl_beat;
  logic [CNT_W-1:0] r_req_cnt;
  logic [CNT_W-1:0] r_cpl_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_frm_cnt;

  always_comb begin
    w_cls = C_DROP;
    if (!in_error) begin
      if (in_data[28:24] == 5'b00000)      w_cls = C_REQ;
      else if (in_data[28:24] == 5'b01010) w_cls = C_CPL;
    end
  end

  always_comb begin
    w_rdy = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (in_startofpacket) begin
          if (w_cls == C_REQ)      w_rdy = w_req_buf_rdy;
          else if (w_cls == C_CPL) w_rdy = w_cpl_buf_rdy;
        end
      end
      S_FWD_REQ: w_rdy = w_req_buf_rdy;
      S_FWD_CPL: w_rdy = w_cpl_buf_rdy;
      default:   w_rdy = 1'b1;
    endcase
  end

  assign in_ready = reset_n & w_rdy;
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (in_startofpacket && !in_endofpacket) begin
            if (w_cls == C_REQ)      w_state_nxt = S_FWD_REQ;
            else if (w_cls == C_CPL) w_state_nxt = S_FWD_CPL;
            else                     w_state_nxt = S_DROP;
          end
        end
        S_FWD_REQ, S_FWD_CPL: begin
          if (in_startofpacket || in_endofpacket) w_state_nxt = S_IDLE;
        end
        default: begin
          if (in_endofpacket) w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_req_push    = 1'b0;
    w_cpl_push    = 1'b0;
    w_force_close = 1'b0;
    w_inc_req     = 1'b0;
    w_inc_cpl     = 1'b0;
    w_inc_drop    = 1'b0;
    w_inc_frm     = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (in_startofpacket) begin
            w_req_push = (w_cls == C_REQ);
            w_cpl_push = (w_cls == C_CPL);
            w_inc_req  = (w_cls == C_REQ);
            w_inc_cpl  = (w_cls == C_CPL);
            w_inc_drop = (w_cls == C_DROP);
          end else begin
            w_inc_frm = 1'b1;
          end
        end
        S_FWD_REQ, S_FWD_CPL: begin
          w_req_push    = (r_state == S_FWD_REQ);
          w_cpl_push    = (r_state == S_FWD_CPL);
          // An SOP inside an open packet closes it with an error-flagged EOP
          w_force_close = in_startofpacket;
          w_inc_frm     = in_startofpacket;
        end
        default: w_inc_frm = in_startofpacket;
      endcase
    end
  end

  assign w_fwd_beat = w_force_close ? {in_data, 3'b000, 1'b0, 1'b1, 1'b1}
                                    : {in_data, in_empty, in_startofpacket, in_endofpacket, in_error};

  pcie_tlp_rx_router_skid #(.W(262)) u_req_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_req_push),
    .i_beat  (w_fwd_beat),
    .o_ready (w_req_buf_rdy),
    .o_valid (req_valid),
    .o_beat  (w_req_beat),
    .i_ready (req_ready)
  );

  pcie_tlp_rx_router_skid #(.W(262)) u_cpl_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_cpl_push),
    .i_beat  (w_fwd_beat),
    .o_ready (w_cpl_buf_rdy),
    .o_valid (cpl_valid),
    .o_beat  (w_cpl_beat),
    .i_ready (cpl_ready)
  );

  assign {req_data, req_empty, req_startofpacket, req_endofpacket, req_error} = w_req_beat;
  assign {cpl_data, cpl_empty, cpl_startofpacket, cpl_endofpacket, cpl_error} = w_cpl_beat;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_req_cnt  <= '0;
      r_cpl_cnt  <= '0;
      r_drop_cnt <= '0;
      r_frm_cnt  <= '0;
    end else begin
      if (w_inc_req  && (r_req_cnt  != {CNT_W{1'b1}})) r_req_cnt  <= r_req_cnt  + 1'b1;
      if (w_inc_cpl  && (r_cpl_cnt  != {CNT_W{1'b1}})) r_cpl_cnt  <= r_cpl_cnt  + 1'b1;
      if (w_inc_drop && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_inc_frm  && (r_frm_cnt  != {CNT_W{1'b1}})) r_frm_cnt  <= r_frm_cnt  + 1'b1;
    end
  end

  assign req_pkt_count     = r_req_cnt;
  assign cpl_pkt_count     = r_cpl_cnt;
  assign drop_count        = r_drop_cnt;
  assign framing_err_count = r_frm_cnt;
endmodule

// File: tb/tb_pcie_tlp_rx_router.sv
// tb/tb_pcie_tlp_rx_router.sv - scoreboard bench for pcie_tlp_rx_router
`timescale 1ns/1ps

module tb_pcie_tlp_rx_router;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] in_data;
  logic [2:0]   in_empty;
  logic         in_startofpacket, in_endofpacket, in_error, in_valid, in_ready;
  logic [255:0] req_data, cpl_data;
  logic [2:0]   req_empty, cpl_empty;
  logic         req_startofpacket, req_endofpacket, req_error, req_valid, req_ready;
  logic         cpl_startofpacket, cpl_endofpacket, cpl_error, cpl_valid, cpl_ready;
  logic [15:0]  req_pkt_count, cpl_pkt_count, drop_count, framing_err_count;

  int checks = 0;
  int errors = 0;
  logic [261:0] req_q[$];
  logic [261:0] cpl_q[$];

  always #5 clk = ~clk;

  pcie_tlp_rx_router #(.CNT_W(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_error          (in_error),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .req_data          (req_data),
    .req_empty         (req_empty),
    .req_startofpacket (req_startofpacket),
    .req_endofpacket   (req_endofpacket),
    .req_error         (req_error),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .cpl_data          (cpl_data),
    .cpl_empty         (cpl_empty),
    .cpl_startofpacket (cpl_startofpacket),
    .cpl_endofpacket   (cpl_endofpacket),
    .cpl_error         (cpl_error),
    .cpl_valid         (cpl_valid),
    .cpl_ready         (cpl_ready),
    .req_pkt_count     (req_pkt_count),
    .cpl_pkt_count     (cpl_pkt_count),
    .drop_count        (drop_count),
    .framing_err_count (framing_err_count)
  );

  function automatic logic [255:0] mk(input logic [31:0] dw0, input logic [31:0] idx);
    logic [31:0] fill;
    fill = 32'hC0DE_0000 ^ idx;
    return {fill, fill, fill, fill, fill, fill, fill, dw0};
  endfunction

  function automatic logic [261:0] bt(input logic [255:0] d, input logic [2:0] e,
                                      input logic s, input logic eo, input logic er);
    return {d, e, s, eo, er};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [255:0] d, input logic [2:0] e,
                       input logic s, input logic eo, input logic er);
    logic ok;
    ok               = 1'b0;
    in_data          = d;
    in_empty         = e;
    in_startofpacket = s;
    in_endofpacket   = eo;
    in_error         = er;
    in_valid         = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: got in_ready=0 expected acceptance within 200 cycles");
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [261:0] e;
    if (reset_n && req_valid && req_ready) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got beat %0h expected none",
                 {req_data, req_empty, req_startofpacket, req_endofpacket, req_error});
      end else begin
        e = req_q.pop_front();
        if ({req_data, req_empty, req_startofpacket, req_endofpacket, req_error} !== e) begin
          errors++;
          $display("FAIL req_beat: got %0h expected %0h",
                   {req_data, req_empty, req_startofpacket, req_endofpacket, req_error}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [261:0] e;
    if (reset_n && cpl_valid && cpl_ready) begin
      checks++;
      if (cpl_q.size() == 0) begin
        errors++;
        $display("FAIL cpl_unexpected: got beat %0h expected none",
                 {cpl_data, cpl_empty, cpl_startofpacket, cpl_endofpacket, cpl_error});
      end else begin
        e = cpl_q.pop_front();
        if ({cpl_data, cpl_empty, cpl_startofpacket, cpl_endofpacket, cpl_error} !== e) begin
          errors++;
          $display("FAIL cpl_beat: got %0h expected %0h",
                   {cpl_data, cpl_empty, cpl_startofpacket, cpl_endofpacket, cpl_error}, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    in_data          = '0;
    in_empty         = 3'd0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_error         = 1'b0;
    in_valid         = 1'b0;
    req_ready        = 1'b1;
    cpl_ready        = 1'b1;
    wait_cycles(3);

    chk("rst_req_valid", req_valid, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_req_data_lo", req_data[63:0], 0);
    chk("rst_counters", {req_pkt_count, cpl_pkt_count, drop_count, framing_err_count}, 0);
    reset_n = 1'b1;
    wait_cycles(1);

    // 3-beat MWr
    req_q.push_back(bt(mk(32'h4000_0010, 0), 3'd0, 1'b1, 1'b0, 1'b0));
    req_q.push_back(bt(mk(32'h1111_0001, 1), 3'd0, 1'b0, 1'b0, 1'b0));
    req_q.push_back(bt(mk(32'h1111_0002, 2), 3'd2, 1'b0, 1'b1, 1'b0));
    drive(mk(32'h4000_0010, 0), 3'd0, 1'b1, 1'b0, 1'b0);
    chk("t1_latency", req_valid, 1);
    drive(mk(32'h1111_0001, 1), 3'd0, 1'b0, 1'b0, 1'b0);
    drive(mk(32'h1111_0002, 2), 3'd2, 1'b0, 1'b1, 1'b0);
    wait_cycles(3);
    chk("t1_req_q_empty", req_q.size(), 0);
    chk("t1_req_pkt", req_pkt_count, 1);
    chk("t1_cpl_pkt", cpl_pkt_count, 0);

    // single-beat CplD
    cpl_q.push_back(bt(mk(32'h4A00_0001, 3), 3'd3, 1'b1, 1'b1, 1'b0));
    drive(mk(32'h4A00_0001, 3), 3'd3, 1'b1, 1'b1, 1'b0);
    wait_cycles(3);
    chk("t2_cpl_q_empty", cpl_q.size(), 0);
    chk("t2_cpl_pkt", cpl_pkt_count, 1);

    // REQ, CPL, REQ back to back with the completion sink stalled
    cpl_ready = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 cpl_ready = 1'b1;
      end
    join_none
    req_q.push_back(bt(mk(32'h6000_0020, 4), 3'd0, 1'b1, 1'b0, 1'b0));
    req_q.push_back(bt(mk(32'h2222_0001, 5), 3'd1, 1'b0, 1'b1, 1'b1));
    cpl_q.push_back(bt(mk(32'h0A00_0002, 6), 3'd0, 1'b1, 1'b0, 1'b0));
    cpl_q.push_back(bt(mk(32'h3333_0001, 7), 3'd4, 1'b0, 1'b1, 1'b0));
    req_q.push_back(bt(mk(32'h0000_0003, 8), 3'd0, 1'b1, 1'b0, 1'b0));
    req_q.push_back(bt(mk(32'h4444_0001, 9), 3'd6, 1'b0, 1'b1, 1'b0));
    drive(mk(32'h6000_0020, 4), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h2222_0001, 5), 3'd1, 1'b0, 1'b1, 1'b1);
    drive(mk(32'h0A00_0002, 6), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h3333_0001, 7), 3'd4, 1'b0, 1'b1, 1'b0);
    drive(mk(32'h0000_0003, 8), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h4444_0001, 9), 3'd6, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    chk("t3_req_flowed", req_q.size(), 0);
    chk("t3_cpl_held", cpl_q.size(), 2);
    chk("t3_cpl_valid_held", cpl_valid, 1);
    in_data          = mk(32'h4A00_0010, 10);
    in_empty         = 3'd0;
    in_startofpacket = 1'b1;
    in_endofpacket   = 1'b0;
    in_error         = 1'b0;
    in_valid         = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_stall", in_ready, 0);
    cpl_q.push_back(bt(mk(32'h4A00_0010, 10), 3'd0, 1'b1, 1'b0, 1'b0));
    cpl_q.push_back(bt(mk(32'h5555_0001, 11), 3'd5, 1'b0, 1'b1, 1'b0));
    drive(mk(32'h4A00_0010, 10), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h5555_0001, 11), 3'd5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 50 && (req_q.size() != 0 || cpl_q.size() != 0); i++) wait_cycles(1);
    chk("t3_all_delivered", req_q.size() + cpl_q.size(), 0);
    chk("t3_req_pkt", req_pkt_count, 3);
    chk("t3_cpl_pkt", cpl_pkt_count, 3);

    // Cfg read and an errored MRd are both dropped
    drive(mk(32'h0400_0001, 12), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h6666_0001, 13), 3'd0, 1'b0, 1'b1, 1'b0);
    drive(mk(32'h0000_0001, 14), 3'd0, 1'b1, 1'b0, 1'b1);
    drive(mk(32'h7777_0001, 15), 3'd0, 1'b0, 1'b1, 1'b0);
    wait_cycles(3);
    chk("t4_drop", drop_count, 2);
    chk("t4_no_valid", {req_valid, cpl_valid}, 0);
    chk("t4_framing", framing_err_count, 0);

    // SOP arriving inside an open MRd forces an error-flagged close
    req_q.push_back(bt(mk(32'h0000_0004, 16), 3'd0, 1'b1, 1'b0, 1'b0));
    req_q.push_back(bt(mk(32'h4A00_0005, 17), 3'd0, 1'b0, 1'b1, 1'b1));
    drive(mk(32'h0000_0004, 16), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h4A00_0005, 17), 3'd5, 1'b1, 1'b0, 1'b0);
    wait_cycles(3);
    chk("t5_req_q_empty", req_q.size(), 0);
    chk("t5_framing", framing_err_count, 1);
    chk("t5_req_pkt", req_pkt_count, 4);
    chk("t5_cpl_pkt", cpl_pkt_count, 3);

    // fresh reset, orphan beat, then saturate drop_count
    reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(1);
    chk("t6_counters_clear", {req_pkt_count, cpl_pkt_count, drop_count, framing_err_count}, 0);
    drive(mk(32'h8888_0001, 18), 3'd0, 1'b0, 1'b1, 1'b0);
    wait_cycles(1);
    chk("t6_orphan_framing", framing_err_count, 1);
    for (int i = 0; i < 65536; i++) drive(mk(32'h0400_0000, i), 3'd0, 1'b1, 1'b1, 1'b0);
    wait_cycles(2);
    chk("t6_drop_saturated", drop_count, 16'hFFFF);
    chk("t6_framing_kept", framing_err_count, 1);
    chk("t6_no_valid", {req_valid, cpl_valid}, 0);

    // reset mid-packet with beats still buffered
    req_ready = 1'b0;
    drive(mk(32'h0000_0009, 19), 3'd0, 1'b1, 1'b0, 1'b0);
    drive(mk(32'h9999_0001, 20), 3'd0, 1'b0, 1'b0, 1'b0);
    chk("t6_buffered", req_valid, 1);
    reset_n = 1'b0;
    wait_cycles(1);
    chk("t6_rst_valids", {req_valid, cpl_valid}, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_req_data", req_data[63:0], 0);
    chk("t6_rst_counters", {req_pkt_count, cpl_pkt_count, drop_count, framing_err_count}, 0);
    reset_n   = 1'b1;
    req_ready = 1'b1;
    wait_cycles(5);
    chk("t6_post_rst_valid", {req_valid, cpl_valid}, 0);
    chk("end_queues_empty", req_q.size() + cpl_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_tlp_rx_router.md
Name: pcie_tlp_rx_router

Overview:
Downstream consumer of the TLP RX adapter's tlp_rx_st stream: 256-bit Avalon-ST, empty in 32-bit dwords.
- Decodes DW0 of each TLP on its SOP beat and classifies it.
- Steers memory requests to a request source and completions to a completion source.
- Drops every other TLP type and every malformed packet; keeps saturating statistics counters.
- Each output carries a 2-entry skid buffer, so one beat per cycle sustains back-to-back packets.

Parameters:
CNT_W, 16, width of each statistics counter (saturating).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active low
in_data  in  256  TLP beat; DW0 in [31:0], fmt=[31:29], type=[28:24]
in_empty  in  3  unused dwords in the EOP beat (0..7)
in_startofpacket  in  1  SOP
in_endofpacket  in  1  EOP
in_error  in  1  beat error
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
req_data/req_empty/req_startofpacket/req_endofpacket/req_error/req_valid  out  256/3/1/1/1/1  request source
req_ready  in  1  request sink ready
cpl_data/cpl_empty/cpl_startofpacket/cpl_endofpacket/cpl_error/cpl_valid  out  256/3/1/1/1/1  completion source
cpl_ready  in  1  completion sink ready
req_pkt_count  out  CNT_W  request TLPs forwarded
cpl_pkt_count  out  CNT_W  completion TLPs forwarded
drop_count  out  CNT_W  TLPs dropped (unsupported type or SOP error)
framing_err_count  out  CNT_W  framing violations

Behaviour:
- Handshake: Avalon-ST, readyLatency 0. A beat transfers when valid & ready.
- Reset: while reset_n is low at a clk edge:
  - state = IDLE; both skid buffers emptied.
  - All *_valid = 0; all data/empty/sop/eop/error outputs = 0; all counters = 0.
  - in_ready = 0 while reset_n is low.
- Reset mid-packet aborts the packet: buffered beats are discarded and no EOP is emitted.
- Classification on the SOP beat, from type = in_data[28:24]:
  - 5'b00000 (MRd/MWr, any fmt) → REQ.
  - 5'b01010 (Cpl/CplD) → CPL.
  - Any other type → DROP.
  - An SOP beat with in_error = 1 → DROP regardless of type.
- FSM states: IDLE, FWD_REQ, FWD_CPL, DROP.
  - IDLE, SOP beat accepted: REQ/CPL goes to FWD_REQ/FWD_CPL; DROP goes to DROP.
  - If that SOP beat also has EOP (single-beat TLP), the state returns to IDLE immediately.
  - IDLE, non-SOP beat: consumed and discarded; framing_err_count++.
  - FWD_x, EOP beat: forwarded, then state → IDLE.
  - DROP, EOP beat: discarded, then state → IDLE. drop_count++ once per dropped packet, counted at its SOP.
  - FWD_x, SOP beat (missing EOP): beat written to destination x with sop=0, eop=1, error=1, empty=0. This closes the open packet. framing_err_count++, state → IDLE; the new packet is lost.
  - DROP, SOP beat: discarded; framing_err_count++; state stays DROP until an EOP.
- in_ready is combinational from state and buffer status:
  - IDLE: 1 for a non-SOP beat.
  - IDLE, SOP beat: ready of the classified buffer, or 1 if DROP.
  - FWD_REQ / FWD_CPL: ready of that buffer.
  - DROP: 1.
- Buffer ready = "not full", taken from a register.
- Forwarded beats copy data/empty/sop/eop/error unchanged (except the forced-close case above). An in_error on a non-SOP beat passes through on *_error.
- Latency: an accepted beat appears on the output valid in the next cycle.
- Skid buffer: 2 entries, FIFO order. Simultaneous push and pop when full is not possible, because ready is deasserted.
- A full buffer stalls only its own path. A DROP packet drains even while both outputs are stalled.
- Packet counters: req_pkt_count and cpl_pkt_count increment on acceptance of each forwarded SOP beat.
- Counter saturation: all counters hold at 2^CNT_W-1. Simultaneous increments to different counters are independent.

Test Plan:
- Reset, then a 3-beat MWr, DW0 = 32'h4000_0010, empty = 3'h2 on EOP → 3 beats on req, in order, 1-cycle latency; req_pkt_count = 1; cpl_valid stays 0.
- Single-beat CplD, DW0 = 32'h4A00_0001, sop = eop = 1 → one cpl beat with sop = eop = 1; cpl_pkt_count = 1.
- Back-to-back REQ, CPL, REQ (2 beats each), cpl_ready held 0 for 10 cycles → req stream continues. in_ready drops once the CPL buffer holds 2 beats. All beats are delivered once cpl_ready = 1 and none are lost.
- Cfg read, DW0 = 32'h0400_0001, 2 beats; then an MRd with in_error = 1 on SOP → both dropped, drop_count = 2, no output valid.
- MRd SOP, then another SOP before any EOP → req gets beat 1, then a beat with eop = 1, error = 1; framing_err_count = 1.
- Orphan non-SOP beat in IDLE; drive 65536 dropped packets with CNT_W = 16 → framing_err_count = 1; drop_count saturates at 16'hFFFF. Pulse reset_n low mid-packet → all counters 0, all valids 0.
